// File: rtl/icg_wake_sched_pkg.sv
// ---------------------------------------------------------------------------
// icg_wake_sched_pkg : shared channel state encoding and default parameters
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package icg_wake_sched_pkg;

  localparam int NCH_DEF      = 4;
  localparam int CW_DEF       = 8;
  localparam int WAKE_LAT_DEF = 2;

  // Gray-adjacent: E = |state, ACK = state[1]
  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_WAKE = 2'b01,
    ST_ON   = 2'b11,
    ST_IDLE = 2'b10
  } chan_state_e;

endpackage

`default_nettype wire

// File: rtl/icg_wake_sched_if.sv
// ---------------------------------------------------------------------------
// icg_wake_sched_if : request/override/enable bundle for the ICG wake scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface icg_wake_sched_if
  import icg_wake_sched_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
);

  logic [NCH-1:0] REQ;
  logic [NCH-1:0] FORCE_ON;
  logic [CW-1:0]  IDLE_LIM;
  logic [NCH-1:0] E;
  logic [NCH-1:0] ACK;
  logic           BUSY;

  modport master (
    output REQ, FORCE_ON, IDLE_LIM,
    input  E, ACK, BUSY
  );

  modport slave (
    input  REQ, FORCE_ON, IDLE_LIM,
    output E, ACK, BUSY
  );

endinterface

`default_nettype wire

// File: rtl/icg_wake_chan.sv
// ---------------------------------------------------------------------------
// icg_wake_chan : one clock-gate channel FSM (OFF/WAKE/ON/IDLE) with counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icg_wake_chan
  import icg_wake_sched_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int WAKE_LAT = WAKE_LAT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          grant_i,
  input  logic          pending_i,
  input  logic [CW-1:0] idle_lim_i,
  output chan_state_e   state_o,
  output logic          e_o,
  output logic          ack_o
);

  localparam logic [CW-1:0] C_WAKE_LOAD = CW'(WAKE_LAT - 1);

  chan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (grant_i) begin
          state_d = ST_WAKE;
          cnt_d   = C_WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt_q == '0) state_d = ST_ON;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ON: begin
        if (!pending_i) begin
          if (idle_lim_i == '0) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = idle_lim_i - 1'b1;
          end
        end
      end
      ST_IDLE: begin
        // a request arriving on the expiry edge keeps the gate open
        if (pending_i)         state_d = ST_ON;
        else if (cnt_q == '0)  state_d = ST_OFF;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  assign state_o = state_q;
  assign e_o     = state_q[0] | state_q[1];
  assign ack_o   = state_q[1];

endmodule

`default_nettype wire

// File: rtl/icg_wake_sched.sv
// ---------------------------------------------------------------------------
// icg_wake_sched : round-robin serialized wake-up of NCH clock-gate enables
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icg_wake_sched
  import icg_wake_sched_pkg::*;
#(
  parameter int NCH      = NCH_DEF,
  parameter int CW       = CW_DEF,
  parameter int WAKE_LAT = WAKE_LAT_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  icg_wake_sched_if.slave  bus
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] pending_w;
  logic [NCH-1:0] grant_w;
  logic [NCH-1:0] off_w;
  logic [NCH-1:0] wake_w;
  logic [NCH-1:0] e_w;
  logic [NCH-1:0] ack_w;
  chan_state_e    state_w [NCH];

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW:0]    idx_sum;
  logic [PW-1:0]  idx;
  logic           found;

  assign pending_w = bus.REQ | bus.FORCE_ON;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_chan
      icg_wake_chan #(
        .CW       (CW),
        .WAKE_LAT (WAKE_LAT)
      ) u_chan (
        .clk_i      (CLK),
        .rst_i      (RST),
        .grant_i    (grant_w[g]),
        .pending_i  (pending_w[g]),
        .idle_lim_i (bus.IDLE_LIM),
        .state_o    (state_w[g]),
        .e_o        (e_w[g]),
        .ack_o      (ack_w[g])
      );
      assign off_w[g]  = (state_w[g] == ST_OFF);
      assign wake_w[g] = (state_w[g] == ST_WAKE);
    end
  endgenerate

  // Scan from the pointer; a grant is only issued while no channel is waking
  always_comb begin
    grant_w = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx_sum = '0;
    idx     = '0;
    for (int k = 0; k < NCH; k++) begin
      idx_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx_sum >= (PW+1)'(NCH)) idx_sum = idx_sum - (PW+1)'(NCH);
      idx = idx_sum[PW-1:0];
      if (!found && !(|wake_w) && pending_w[idx] && off_w[idx]) begin
        found        = 1'b1;
        grant_w[idx] = 1'b1;
        ptr_d        = (idx == PW'(NCH - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign bus.E    = e_w;
  assign bus.ACK  = ack_w;
  assign bus.BUSY = |wake_w;

endmodule

`default_nettype wire

// File: doc/icg_wake_sched.md
Name: icg_wake_sched

Overview:
- Controller that sequences the enables of NCH integrated clock-gate cells (E pins) in the gf180mcu 9-track library.
- Each clock consumer raises a request; the block turns its gate on and acknowledges once the gated clock has settled.
- Gates are held on through an idle timeout and then switched off.
- Wake-ups are serialized with round-robin arbitration so at most one gate turns on at a time, limiting supply inrush on the 5 V rail.

Parameters:
- NCH, 4, number of gated clock channels (2..16).
- CW, 8, width of the idle/wake counters.
- WAKE_LAT, 2, cycles from E rising to ACK rising (1..2^CW-1).

Ports:
- CLK  input  1  controller clock (ungated, free-running).
- RST  input  1  synchronous reset, active-high; sampled on CLK rising edge.
- REQ  input  NCH  per-channel clock request, level.
- FORCE_ON  input  NCH  per-channel software override; treated as a permanent request.
- IDLE_LIM  input  CW  idle timeout in cycles; quasi-static, sampled when a channel enters IDLE.
- E  output  NCH  gate enable to each ICG E pin; registered.
- ACK  output  NCH  gated clock valid for channel; registered.
- BUSY  output  1  high while any channel is in WAKE.

Behaviour:
- Reset (synchronous, wins over all other inputs):
  - All channels go to OFF; E=0, ACK=0, BUSY=0.
  - Round-robin pointer=0; all counters=0.
  - Asserting RST mid-operation drops E/ACK at that edge regardless of state.
- Per-channel states: OFF, WAKE, ON, IDLE. Pending(i) = REQ[i] | FORCE_ON[i].
- OFF:
  - E=0, ACK=0.
  - Moves to WAKE only when granted; grant happens on an edge where pending(i)=1 and no channel is in WAKE or being granted.
- Arbitration:
  - At most one grant per cycle.
  - Round-robin starting at the pointer; pointer moves to grantee+1 (mod NCH) on grant.
  - Ungranted requesters stay in OFF and keep requesting.
- WAKE:
  - E=1, ACK=0.
  - Counter loads WAKE_LAT-1 on entry and decrements; at 0 the channel goes to ON.
  - Timing: E rises at edge k, ACK rises at edge k+WAKE_LAT.
  - A request dropped during WAKE does not abort it; the channel completes to ON, then follows ON rules.
- ON:
  - E=1, ACK=1.
  - If pending=0: when IDLE_LIM=0, go directly to OFF (E and ACK fall next edge); otherwise go to IDLE with counter=IDLE_LIM-1.
- IDLE:
  - E=1, ACK=1.
  - If pending=1, return to ON (counter discarded).
  - Else decrement; at 0 go to OFF.
  - Result: E stays high for IDLE_LIM cycles after the first cycle with pending=0.
- Simultaneous events:
  - pending re-rising on the same edge IDLE expires takes priority; channel goes to ON.
  - A channel in OFF re-requesting is treated as a new wake and must re-arbitrate.
- BUSY = OR of (state==WAKE), registered alongside state.
- E and ACK decode directly from state flops, so there are no glitches at the ICG E pin.
- Counter arithmetic is unsigned CW-bit with no wrap: counters never decrement below 0.
- REQ and FORCE_ON are synchronous to CLK; synchronizing asynchronous sources is the requester's responsibility.

Decomposition:
- Shared package holds:
  - state enum (OFF=2'b00, WAKE=2'b01, ON=2'b11, IDLE=2'b10; Gray-adjacent so E = state[0]|state[1], ACK = state[1]);
  - default parameter constants.
- Sub-module icg_wake_chan: one-channel FSM plus counter, inputs grant/pending/idle_lim, outputs state/e/ack; instantiated NCH times.
- The round-robin arbiter stays in the top level.

Test Plan:
1. Reset then REQ[0]=1 at edge 1 (WAKE_LAT=2): E[0]=1 at edge 2, ACK[0]=1 at edge 4, BUSY high for edges 2-3 only.
2. REQ[0]=0 with IDLE_LIM=3: E[0]/ACK[0] stay 1 for 3 cycles, both 0 on the 4th edge. Repeat with IDLE_LIM=0: both drop on the next edge.
3. REQ=4'b1111 from reset: E rises in the order ch0, ch1, ch2, ch3, with exactly one WAKE at a time and ACK spaced WAKE_LAT+1 cycles apart. Then pointer=0 again, so re-request order continues ch0 first.
4. In IDLE with counter at 0, REQ re-asserts on the expiry edge: channel goes to ON, E never drops.
5. FORCE_ON[2]=1 with REQ[2]=0 for 100 cycles: E[2]/ACK[2] stay 1 throughout; channel goes to IDLE once FORCE_ON clears.
6. RST asserted for one cycle while ch1 is in WAKE and ch3 is ON: all E/ACK/BUSY=0 at that edge, a pending ch1 re-arbitrates from pointer 0.
